// File: rtl/clk_div_prog.sv
// Programmable clock-enable generator: 1-cycle tick every N enabled cycles plus optional square wave.
// Define CLKDIV_PHASE_EN to expose the live counter on the phase port.
module clk_div_prog #(
  parameter int WIDTH       = 7,
  parameter int DEFAULT_DIV = 100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             div_load,
  input  logic [WIDTH-1:0] div_in,
  input  logic             mode_in,
  output logic             tick,
  output logic             clk_out,
  output logic             pending
`ifdef CLKDIV_PHASE_EN
  ,
  output logic [WIDTH-1:0] phase
`endif
);

  // state       | meaning
  // IDLE        | en=0, cnt=0: loads apply directly
  // RUN         | counting, no setting waiting
  // RUN_PENDING | counting, shadow setting applies at next terminal count

  localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] MIN_DIV = WIDTH'(2);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] div;
  logic             mode;
  logic [WIDTH-1:0] shadow_div;
  logic             shadow_mode;

  logic [WIDTH-1:0] div_clamped;
  logic [WIDTH-1:0] half;
  logic             tc;
  logic             idle;

  assign div_clamped = (div_in < MIN_DIV) ? MIN_DIV : div_in;
  // ceil(div/2) without widening, so div = 2^WIDTH-1 cannot overflow
  assign half        = {1'b0, div[WIDTH-1:1]} + {{(WIDTH-1){1'b0}}, div[0]};
  assign tc          = en && (cnt == div - WIDTH'(1));
  assign idle        = !en && (cnt == '0);

`ifdef CLKDIV_PHASE_EN
  assign phase = cnt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      div         <= DEF_DIV;
      mode        <= 1'b0;
      shadow_div  <= '0;
      shadow_mode <= 1'b0;
      pending     <= 1'b0;
      tick        <= 1'b0;
      clk_out     <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (en) begin
        cnt     <= tc ? '0 : cnt + WIDTH'(1);
        tick    <= tc;
        clk_out <= mode && (cnt < half);
      end

      // A load on the terminal-count edge governs the period starting at that edge.
      if (div_load && (idle || tc)) begin
        div     <= div_clamped;
        mode    <= mode_in;
        pending <= 1'b0;
      end else if (div_load) begin
        shadow_div  <= div_clamped;
        shadow_mode <= mode_in;
        pending     <= 1'b1;
      end else if (tc && pending) begin
        div     <= shadow_div;
        mode    <= shadow_mode;
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed self-checking bench for clk_div_prog.
module tb_clk_div_prog;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       div_load;
  logic [6:0] div_in;
  logic       mode_in;
  logic       tick;
  logic       clk_out;
  logic       pending;
`ifdef CLKDIV_PHASE_EN
  logic [6:0] phase;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  clk_div_prog #(.WIDTH(7), .DEFAULT_DIV(100)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .div_load (div_load),
    .div_in   (div_in),
    .mode_in  (mode_in),
    .tick     (tick),
    .clk_out  (clk_out),
    .pending  (pending)
`ifdef CLKDIV_PHASE_EN
    ,
    .phase    (phase)
`endif
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_idle(input logic [6:0] d, input logic m);
    en = 1'b0; div_load = 1'b1; div_in = d; mode_in = m;
    cyc();
    div_load = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; div_load = 1'b0; div_in = '0; mode_in = 1'b0;

    // 1: reset, then default divide-by-100 in pulse mode
    cyc(); cyc();
    chk("rst_tick", tick, 0);
    chk("rst_clk_out", clk_out, 0);
    chk("rst_pending", pending, 0);
    rst = 1'b0; en = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      cyc();
      chk($sformatf("t1_tick_%0d", k), tick, (k % 100 == 0) ? 1 : 0);
      chk($sformatf("t1_clk_out_%0d", k), clk_out, 0);
    end

    // 2: idle load N=5 square
    load_idle(7'd5, 1'b1);
    chk("t2_pending", pending, 0);
    en = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      chk($sformatf("t2_clk_out_%0d", k), clk_out, (((k - 1) % 5) < 3) ? 1 : 0);
      chk($sformatf("t2_tick_%0d", k), tick, (k % 5 == 0) ? 1 : 0);
    end

    // 3: mid-period load on N=100 waits for the period boundary
    load_idle(7'd100, 1'b0);
    chk("t3_pending0", pending, 0);
    en = 1'b1;
    for (int k = 1; k <= 30; k++) cyc();
    div_load = 1'b1; div_in = 7'd10; mode_in = 1'b0;
    cyc();
    div_load = 1'b0;
    chk("t3_pending1", pending, 1);
    chk("t3_tick31", tick, 0);
    for (int k = 32; k <= 100; k++) begin
      cyc();
      chk($sformatf("t3_tick_%0d", k), tick, (k == 100) ? 1 : 0);
      chk($sformatf("t3_pend_%0d", k), pending, (k < 100) ? 1 : 0);
    end
    for (int k = 1; k <= 20; k++) begin
      cyc();
      chk($sformatf("t3_new_tick_%0d", k), tick, (k % 10 == 0) ? 1 : 0);
    end

    // 4: divisor 0 and 1 clamp to 2
    load_idle(7'd0, 1'b0);
    en = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      chk($sformatf("t4a_tick_%0d", k), tick, (k % 2 == 0) ? 1 : 0);
    end
    load_idle(7'd1, 1'b1);
    en = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      cyc();
      chk($sformatf("t4b_tick_%0d", k), tick, (k % 2 == 0) ? 1 : 0);
      chk($sformatf("t4b_clk_out_%0d", k), clk_out, (k % 2 == 1) ? 1 : 0);
    end

    // 5: freeze at cnt=4 of N=10
    load_idle(7'd10, 1'b0);
    en = 1'b1;
    for (int k = 1; k <= 4; k++) cyc();
    en = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      cyc();
      chk($sformatf("t5_frozen_tick_%0d", k), tick, 0);
    end
    en = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      cyc();
      chk($sformatf("t5_resume_tick_%0d", k), tick, (k == 6) ? 1 : 0);
    end

    // 6: reset while a setting is pending discards the shadow
    for (int k = 1; k <= 3; k++) cyc();
    div_load = 1'b1; div_in = 7'd7; mode_in = 1'b1;
    cyc();
    div_load = 1'b0;
    chk("t6_pending1", pending, 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("t6_rst_tick", tick, 0);
    chk("t6_rst_clk_out", clk_out, 0);
    chk("t6_rst_pending", pending, 0);
    for (int k = 1; k <= 100; k++) begin
      cyc();
      chk($sformatf("t6_tick_%0d", k), tick, (k == 100) ? 1 : 0);
      chk($sformatf("t6_clk_out_%0d", k), clk_out, 0);
    end

    // 7: load coinciding with terminal count applies immediately
    load_idle(7'd10, 1'b0);
    en = 1'b1;
    for (int k = 1; k <= 9; k++) cyc();
    div_load = 1'b1; div_in = 7'd4; mode_in = 1'b1;
    cyc();
    div_load = 1'b0;
    chk("t7_tc_tick", tick, 1);
    chk("t7_tc_pending", pending, 0);
    for (int k = 1; k <= 8; k++) begin
      cyc();
      chk($sformatf("t7_clk_out_%0d", k), clk_out, (((k - 1) % 4) < 2) ? 1 : 0);
      chk($sformatf("t7_tick_%0d", k), tick, (k % 4 == 0) ? 1 : 0);
    end

    // 8: repeated loads before terminal count, last one wins; square -> pulse
    cyc();
    div_load = 1'b1; div_in = 7'd9; mode_in = 1'b0;
    cyc();
    div_in = 7'd3;
    cyc();
    div_load = 1'b0;
    chk("t8_pending", pending, 1);
    cyc();
    chk("t8_tc_tick", tick, 1);
    chk("t8_tc_pending", pending, 0);
    for (int k = 1; k <= 6; k++) begin
      cyc();
      chk($sformatf("t8_tick_%0d", k), tick, (k % 3 == 0) ? 1 : 0);
      chk($sformatf("t8_clk_out_%0d", k), clk_out, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
